// File: rtl/instr_queue.sv
// instr_queue: in-order FIFO of {pc, raw} beats between instruction fetch and decode.
// Absorbs decode backpressure. A flush drops every queued beat and swallows any
// beat that fetch hands over in the same cycle.
// Optional build macro: INSTR_QUEUE_BYPASS_EN lets a beat reach decode in the
// same cycle it arrives when the queue is empty (zero-latency pass-through).
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fetched_valid_i,
    output logic                     fetched_ready_o,
    input  logic [XLEN-1:0]          fetched_pc_i,
    input  logic [XLEN-1:0]          fetched_raw_i,
    output logic                     decoded_valid_o,
    input  logic                     decoded_ready_i,
    output logic [XLEN-1:0]          decoded_pc_o,
    output logic [XLEN-1:0]          decoded_raw_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2*XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              full;
    logic              empty;
    logic              enqFire;
    logic              deqFire;
    logic              writeEn;
    logic              readEn;
    logic [2*XLEN-1:0] fetchedData;
    logic [2*XLEN-1:0] decodedData;

    assign fetchedData = {fetched_pc_i, fetched_raw_i};
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);

    // Fetch may only hand over a beat when there is room, except during a flush
    // where the beat is accepted and thrown away; dequeue never frees room early.
    assign fetched_ready_o = !rst_i && (!full || flush_i);
    assign enqFire         = fetched_valid_i && fetched_ready_o;

`ifdef INSTR_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming beat straight to decode in the same cycle.
    assign decoded_valid_o = !rst_i && !flush_i && (!empty || fetched_valid_i);
    assign decodedData     = empty ? fetchedData : mem_q[head_q];
    assign deqFire         = decoded_valid_o && decoded_ready_i;
    assign writeEn         = enqFire && !flush_i && !(empty && deqFire);
    assign readEn          = deqFire && !empty;
`else
    // Decode only ever sees stored entries, so minimum latency is one cycle.
    assign decoded_valid_o = !rst_i && !flush_i && !empty;
    assign decodedData     = mem_q[head_q];
    assign deqFire         = decoded_valid_o && decoded_ready_i;
    assign writeEn         = enqFire && !flush_i;
    assign readEn          = deqFire;
`endif

    assign decoded_pc_o  = decodedData[2*XLEN-1:XLEN];
    assign decoded_raw_o = decodedData[XLEN-1:0];
    assign occupancy_o   = count_q;

    // Next-state pointers and count; both-or-neither transfer leaves the count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (writeEn) begin
            tail_d = tail_q + AW'(1);
        end
        if (readEn) begin
            head_d = head_q + AW'(1);
        end
        case ({writeEn, readEn})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset and flush both return the queue to empty.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage array carries no reset; only entries between head and tail are meaningful.
    always_ff @(posedge clk_i) begin
        if (writeEn) begin
            mem_q[tail_q] <= fetchedData;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed plus short random stimulus for instr_queue with a
// queue-based reference model of the expected FIFO contents.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk_i;
    logic            rst_i;
    logic            fetched_valid_i;
    logic            fetched_ready_o;
    logic [XLEN-1:0] fetched_pc_i;
    logic [XLEN-1:0] fetched_raw_i;
    logic            decoded_valid_o;
    logic            decoded_ready_i;
    logic [XLEN-1:0] decoded_pc_o;
    logic [XLEN-1:0] decoded_raw_o;
    logic            flush_i;
    logic [2:0]      occupancy_o;

    int checkCount;
    int errorCount;

    logic [2*XLEN-1:0] scoreboard [$];

    instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fetched_valid_i (fetched_valid_i),
        .fetched_ready_o (fetched_ready_o),
        .fetched_pc_i    (fetched_pc_i),
        .fetched_raw_i   (fetched_raw_i),
        .decoded_valid_o (decoded_valid_o),
        .decoded_ready_i (decoded_ready_i),
        .decoded_pc_o    (decoded_pc_o),
        .decoded_raw_o   (decoded_raw_o),
        .flush_i         (flush_i),
        .occupancy_o     (occupancy_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point: every check in the bench passes through here.
    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare DUT outputs with the model at mid-cycle, then advance the model by
    // the transfers that will happen at the coming clock edge.
    task automatic checkOutput();
        bit expReady;
        bit expValid;
        bit wasEmpty;
        logic [63:0] expData;
        logic [63:0] incoming;
        incoming = {fetched_pc_i, fetched_raw_i};
        wasEmpty = (scoreboard.size() == 0);
        expReady = !rst_i && ((scoreboard.size() < DEPTH) || flush_i);
`ifdef INSTR_QUEUE_BYPASS_EN
        expValid = !rst_i && !flush_i && (!wasEmpty || fetched_valid_i);
`else
        expValid = !rst_i && !flush_i && !wasEmpty;
`endif
        checkValue("fetchedReady", 64'(fetched_ready_o), 64'(expReady));
        checkValue("decodedValid", 64'(decoded_valid_o), 64'(expValid));
        checkValue("occupancy", 64'(occupancy_o), 64'(scoreboard.size()));
        if (expValid) begin
            expData = wasEmpty ? incoming : scoreboard[0];
            checkValue("decodedData", {decoded_pc_o, decoded_raw_o}, expData);
        end
        if (rst_i || flush_i) begin
            scoreboard.delete();
        end else begin
            if (expValid && decoded_ready_i && !wasEmpty) begin
                void'(scoreboard.pop_front());
            end
            if (fetched_valid_i && expReady && !(wasEmpty && expValid && decoded_ready_i)) begin
                scoreboard.push_back(incoming);
            end
        end
    endtask

    // Drive one cycle of inputs just after the edge, check at the falling edge.
    task automatic applyStimulus(input bit fv, input logic [31:0] pc, input logic [31:0] raw,
                                 input bit dr, input bit fl, input bit rs);
        fetched_valid_i = fv;
        fetched_pc_i    = pc;
        fetched_raw_i   = raw;
        decoded_ready_i = dr;
        flush_i         = fl;
        rst_i           = rs;
        @(negedge clk_i);
        checkOutput();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checkCount      = 0;
        errorCount      = 0;
        fetched_valid_i = 1'b0;
        fetched_pc_i    = '0;
        fetched_raw_i   = '0;
        decoded_ready_i = 1'b0;
        flush_i         = 1'b0;
        rst_i           = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkValue("resetOccupancy", 64'(occupancy_o), 64'd0);

        // Fill with decode stalled; the fifth offer must be refused.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 0, 0, 0);
        end
        checkValue("occAfterFill", 64'(occupancy_o), 64'd4);
        applyStimulus(1, 32'h110, 32'hA004, 0, 0, 0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        end
        checkValue("occAfterDrain", 64'(occupancy_o), 64'd0);

        // Steady-state traffic at occupancy 2, pointers wrap several times.
        applyStimulus(1, 32'h500, 32'hB000, 0, 0, 0);
        applyStimulus(1, 32'h504, 32'hB001, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'h508 + 32'(4 * i), 32'hB002 + 32'(i), 1, 0, 0);
        end
        checkValue("occSteady", 64'(occupancy_o), 64'd2);

        // Full plus dequeue: only the dequeue happens.
        applyStimulus(1, 32'h600, 32'hC000, 0, 0, 0);
        applyStimulus(1, 32'h604, 32'hC001, 0, 0, 0);
        applyStimulus(1, 32'h608, 32'hC002, 1, 0, 0);
        checkValue("occFullDeq", 64'(occupancy_o), 64'd3);

        // Refill, then flush while fetch offers 0x200; 0x300 is the next beat seen.
        applyStimulus(1, 32'h60C, 32'hC003, 0, 0, 0);
        applyStimulus(1, 32'h200, 32'hD000, 1, 1, 0);
        checkValue("occAfterFlush", 64'(occupancy_o), 64'd0);
        applyStimulus(1, 32'h300, 32'hD001, 0, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        // Mid-stream reset at occupancy 3.
        applyStimulus(1, 32'h400, 32'hE000, 0, 0, 0);
        applyStimulus(1, 32'h404, 32'hE001, 0, 0, 0);
        applyStimulus(1, 32'h408, 32'hE002, 0, 0, 0);
        applyStimulus(1, 32'h40C, 32'hE003, 1, 0, 1);
        checkValue("occAfterReset", 64'(occupancy_o), 64'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);

        // Empty queue, beat with ready decode: same cycle with bypass, else one later.
        applyStimulus(1, 32'h700, 32'hDEADBEEF, 1, 0, 0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0);
        checkValue("occAfterBypass", 64'(occupancy_o), 64'd0);

        // Short random mix with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i), $urandom,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
